// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler.
// Holds FSM state encoding, default delay width and requester count.
package tick_sched_pkg;

    localparam int CNT_W_DEF = 12;
    localparam int N_REQ     = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_sched_rr_arb2.sv
// Two-way round-robin chooser, purely combinational.
// Ports: req_i requests, rr_i last-granted index, gnt_o one-hot grant.
module rr_arb2
    import tick_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic             rr_i,
    output logic [N_REQ-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // contention: favour the one not granted last
            2'b11:   gnt_o = rr_i ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/tick_sched.sv
// Shared down-counter scheduler: two requesters time delays in ticks.
// Ports: clk_in, reset, tick_en, req, len0/len1 in; gnt, done, busy, cnt_o out.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tick_en,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_o
);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;

    logic [1:0] arb_gnt;
    logic       own_req;
    logic       last;

    rr_arb2 u_arb (
        .req_i (req),
        .rr_i  (rr_q),
        .gnt_o (arb_gnt)
    );

    assign own_req = |(req & gnt_q);
    // a zero length finishes without waiting for a tick
    assign last    = (cnt_q == '0) ||
                     ((cnt_q == CNT_W'(1)) && tick_en);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_RUN;
                    gnt_d   = arb_gnt;
                    cnt_d   = arb_gnt[1] ? len1 : len0;
                    rr_d    = arb_gnt[1];
                end
            end
            S_RUN: begin
                // cancel is checked first so it beats completion
                if (!own_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    done_d  = gnt_q;
                end else if (tick_en) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q == S_RUN);
    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: directed scenarios then random traffic,
// all compared against a behavioural owner/remaining-ticks model.
module tb_tick_sched;

    localparam int W = 12;

    logic         clk_in = 1'b0;
    logic         reset  = 1'b1;
    logic         tick_en = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] len0 = '0;
    logic [W-1:0] len1 = '0;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic [W-1:0] cnt_o;

    int checks = 0;
    int errors = 0;

    // reference model: who owns the counter, ticks left, last winner
    int         owner = -1;
    int         rem   = 0;
    int         rr    = 1;
    logic [1:0] exp_done = 2'b00;

    logic       prev_busy = 1'b0;
    logic [1:0] glog[$];

    tick_sched #(.CNT_W(W)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick_en (tick_en),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt_o   (cnt_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] bit_of(input int who);
        if (who == 0) return 2'b01;
        if (who == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_edge(input logic [1:0] r, input logic t);
        int pick;
        exp_done = 2'b00;
        if (owner < 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) pick = 1 - rr;
                else            pick = r[1] ? 1 : 0;
                owner = pick;
                rr    = pick;
                rem   = (pick == 1) ? int'(len1) : int'(len0);
            end
        end else if (!r[owner]) begin
            owner = -1;
            rem   = 0;
        end else if (rem == 0 || (rem == 1 && t)) begin
            exp_done = bit_of(owner);
            owner    = -1;
            rem      = 0;
        end else if (t) begin
            rem = rem - 1;
        end
    endtask

    task automatic check_outputs();
        chk("gnt",  {30'd0, gnt},  {30'd0, bit_of(owner)});
        chk("done", {30'd0, done}, {30'd0, exp_done});
        chk("busy", {31'd0, busy}, {31'd0, owner >= 0});
        chk("cnt",  {20'd0, cnt_o}, rem);
        chk("onehot", {31'd0, $onehot0(gnt)}, 32'd1);
        chk("done_busy", {31'd0, (done != 2'b00) && busy}, 32'd0);
    endtask

    task automatic step(input logic [1:0] r, input logic t);
        req     = r;
        tick_en = t;
        @(posedge clk_in);
        model_edge(r, t);
        #1;
        check_outputs();
        if (busy && !prev_busy) glog.push_back(gnt);
        prev_busy = busy;
    endtask

    // reset is applied off-edge; outputs must clear at once
    task automatic do_reset();
        reset = 1'b1;
        #1;
        owner     = -1;
        rem       = 0;
        rr        = 1;
        exp_done  = 2'b00;
        prev_busy = 1'b0;
        check_outputs();
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] order_exp[4];
        logic [1:0] r;

        do_reset();

        // single requester, sparse ticks
        len0 = 12'd3;
        for (int i = 0; i < 14; i++) step(2'b01, (i % 4) == 3);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);

        // contention out of reset alternates 0,1,0,1
        do_reset();
        len0 = 12'd2;
        len1 = 12'd2;
        glog.delete();
        for (int i = 0; i < 12; i++) step(2'b11, 1'b1);
        order_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        chk("order_n", {31'd0, glog.size() >= 4}, 32'd1);
        for (int k = 0; k < 4; k++)
            if (k < glog.size())
                chk("order", {30'd0, glog[k]},
                    {30'd0, order_exp[k]});
        step(2'b00, 1'b0);

        // zero length completes next edge without ticks
        len1 = 12'd0;
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);

        // owner drops early, waiting requester takes over
        len0 = 12'd5;
        len1 = 12'd3;
        step(2'b01, 1'b0);
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);

        // drop on the final tick: cancel wins
        len0 = 12'd2;
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);

        // reset in the middle of a delay
        len0 = 12'd6;
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        step(2'b01, 1'b1);
        chk("cnt_pre_rst", {20'd0, cnt_o}, 32'd4);
        do_reset();
        step(2'b11, 1'b0);
        chk("gnt_after_rst", {30'd0, gnt}, 32'd1);
        step(2'b00, 1'b0);

        // random traffic with mid-run length changes
        r = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 5) == 0) r[1] = ~r[1];
            if ($urandom_range(0, 7) == 0)
                len0 = W'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0)
                len1 = W'($urandom_range(0, 6));
            step(r, $urandom_range(0, 2) == 0);
            if (i == 300) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 12, giving the width of each requested delay in base ticks.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick_en, input, 1 bit: base timer pulse (e.g. 0.25 s), one clk_in cycle wide.
REQ-005 The block SHALL have port req, input, 2 bits: level request per requester; held high for the whole delay.
REQ-006 The block SHALL have port len0, input, CNT_W bits: delay length for requester 0, in tick_en pulses.
REQ-007 The block SHALL have port len1, input, CNT_W bits: delay length for requester 1, in tick_en pulses.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant of the shared down-counter; all zero when idle.
REQ-009 The block SHALL have port done, output, 2 bits: one-cycle pulse marking completion for the granted requester.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port cnt_o, output, CNT_W bits: remaining ticks of the current delay; 0 when idle.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no grant) and RUN (one requester owns the counter).
REQ-013 In IDLE, a rising edge with any req bit high SHALL produce the following on that edge: state RUN; one gnt bit set; the matching len latched into the counter; busy=1.
REQ-014 Arbitration SHALL be round-robin via pointer rr = index of the last grant: with both req bits high, the grant goes to index !rr; with one bit high, that requester is granted; rr updates on each grant.
REQ-015 len0/len1 SHALL be sampled only on the grant edge; later changes SHALL have no effect on the running delay.
REQ-016 In RUN, the counter SHALL decrement by 1 on each edge with tick_en=1; tick_en in the grant cycle itself is not counted.
REQ-017 Completion, on an edge in RUN with (counter==1 and tick_en=1) or counter==0, SHALL produce the following: done[g]=1 for exactly one cycle; gnt=0; busy=0; cnt_o=0; state IDLE.
REQ-018 A latched length of 0 SHALL complete on the first edge after grant, independent of tick_en.
REQ-019 If the granted requester's req bit is low on any edge in RUN, the block SHALL cancel: state IDLE; gnt=0; no done pulse. Cancel SHALL win over a simultaneous completion.
REQ-020 The non-granted requester's req SHALL be ignored during RUN; it competes in IDLE only.
REQ-021 A requester still holding req in the done cycle SHALL be eligible at the next edge; rr then favours the other requester.
REQ-022 Minimum latency SHALL be: req high at edge N -> gnt at edge N; done at edge N+1 for length 0. Throughput SHALL be one grant per two cycles at best.
REQ-023 gnt SHALL always be one-hot or zero; done SHALL never assert while busy=1 after the same edge.

Reset
REQ-024 While reset=1, the block SHALL asynchronously hold: state IDLE; gnt=0; done=0; busy=0; cnt_o=0; counter=0; rr=1, so that requester 0 wins the first contention.
REQ-025 Reset asserted mid-RUN SHALL abort the delay with no done pulse; after release, the block SHALL arbitrate afresh from IDLE.

Structure
REQ-026 State encoding (IDLE/RUN), the CNT_W default, and the requester count (2) SHALL live in a shared package/header tick_sched_pkg.
REQ-027 The round-robin choice SHALL be a separate sub-module rr_arb2: inputs req[1:0] and rr; output one-hot grant; purely combinational. All registers SHALL stay in tick_sched.

Verification
REQ-028 Bench SHALL cover: req=01, len0=3, tick_en every 4th cycle -> gnt=01 on the next edge; cnt_o 3,2,1; done=01 on the edge of the 3rd tick_en; gnt=00 the same cycle.
REQ-029 Bench SHALL cover: req=11 out of reset, len0=2, len1=2, both held -> order of grants 0,1,0,1; never two gnt bits high.
REQ-030 Bench SHALL cover: req=10, len1=0 -> gnt=10 at edge N, done=10 at edge N+1 with tick_en held 0.
REQ-031 Bench SHALL cover: req=01, len0=5, req0 dropped after 2 ticks -> gnt=00 next edge, no done pulse; pending req1 then granted.
REQ-032 Bench SHALL cover: req0 dropped on the same edge as the final tick -> no done pulse (cancel wins).
REQ-033 Bench SHALL cover: reset=1 pulsed mid-RUN with cnt_o=4 -> all outputs 0 immediately, no done; after release, req=11 -> gnt=01.
